// File: rtl/snes_controller_reader.sv
// Polls an SNES-style serial pad once per frame: pulses latch, clocks out 16
// active-low bits, then publishes the button flags and a priority-encoded key code.
module snes_controller_reader #(
    parameter int LATCH_CYCLES    = 600,
    parameter int HALF_BIT_CYCLES = 300,
    parameter int POLL_CYCLES     = 833333
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        snes_data,
    output logic        snes_latch,
    output logic        snes_clk,
    output logic [11:0] buttons,
    output logic [7:0]  key_code,
    output logic        key_latch,
    output logic        controller_present,
    output logic [1:0]  debug_state
);

    localparam int PCW    = $clog2(POLL_CYCLES);
    localparam int PH_MAX = (LATCH_CYCLES > 2 * HALF_BIT_CYCLES) ? LATCH_CYCLES : 2 * HALF_BIT_CYCLES;
    localparam int PHW    = $clog2(PH_MAX);

    localparam logic [PCW-1:0] POLL_LAST  = PCW'(POLL_CYCLES - 1);
    localparam logic [PHW-1:0] LATCH_LAST = PHW'(LATCH_CYCLES - 1);
    localparam logic [PHW-1:0] LOW_LAST   = PHW'(HALF_BIT_CYCLES - 1);
    localparam logic [PHW-1:0] BIT_LAST   = PHW'(2 * HALF_BIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

    state_t           state;
    logic [PCW-1:0]   poll_cnt;
    logic [PHW-1:0]   phase;
    logic [4:0]       pulse;
    logic [15:0]      shreg;
    logic             data_s1;
    logic             data_s2;

    logic             present_next;
    logic [11:0]      buttons_next;
    logic [7:0]       code_next;

    assign debug_state = state;

    // Idle level of the pad line is released (1), so the synchronizer resets high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            data_s1 <= snes_data;
            data_s2 <= data_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= '0;
        end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + PCW'(1);
        end
    end

    // A pad that is unplugged reads all zeros, so bits 12..15 double as a presence check.
    always_comb begin
        present_next = &shreg[15:12];
        buttons_next = present_next ? ~shreg[11:0] : 12'h000;
        code_next    = 8'h00;
        for (int i = 11; i >= 0; i--) begin
            if (buttons_next[i]) begin
                code_next = 8'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            snes_latch         <= 1'b0;
            snes_clk           <= 1'b1;
            phase              <= '0;
            pulse              <= '0;
            shreg              <= '0;
            buttons            <= '0;
            key_code           <= '0;
            key_latch          <= 1'b0;
            controller_present <= 1'b0;
        end else begin
            key_latch <= 1'b0;
            case (state)
                IDLE: begin
                    if (poll_cnt == '0) begin
                        state      <= LATCH;
                        snes_latch <= 1'b1;
                        phase      <= '0;
                    end
                end
                LATCH: begin
                    if (phase == LATCH_LAST) begin
                        shreg[0]   <= data_s2;
                        snes_latch <= 1'b0;
                        snes_clk   <= 1'b0;
                        pulse      <= 5'd1;
                        phase      <= '0;
                        state      <= SHIFT;
                    end else begin
                        phase <= phase + PHW'(1);
                    end
                end
                SHIFT: begin
                    if (phase == LOW_LAST) begin
                        snes_clk <= 1'b1;
                        phase    <= phase + PHW'(1);
                    end else if (phase == BIT_LAST) begin
                        phase <= '0;
                        // Pulse 16 only returns the clock high; its bit slot is unused.
                        if (pulse == 5'd16) begin
                            state <= DONE;
                        end else begin
                            shreg[pulse[3:0]] <= data_s2;
                            pulse             <= pulse + 5'd1;
                            snes_clk          <= 1'b0;
                        end
                    end else begin
                        phase <= phase + PHW'(1);
                    end
                end
                DONE: begin
                    controller_present <= present_next;
                    buttons            <= buttons_next;
                    key_code           <= code_next;
                    key_latch          <= 1'b1;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
